// File: rtl/ship_controller_if.sv
// Shot handshake between the player ship and the bullet engine.
interface ship_controller_if;
  logic       shot_valid;
  logic [9:0] shot_x;
  logic       shot_ack;

  modport master (output shot_valid, output shot_x, input shot_ack);
  modport slave  (input shot_valid, input shot_x, output shot_ack);
endinterface

// File: rtl/ship_controller.sv
// Player ship: movement, magazine with fire/ack handshake, reload and
// hit/respawn sequencing, plus the sprite pixel for the VGA mux.
//
// state  | meaning
// READY  | idle, a fire edge with ammo left issues a shot
// SHOT   | shot_valid held until the bullet engine acknowledges
// RELOAD | magazine empty, refilled after RELOAD_FRAMES frames
// DEAD   | ship hit, sprite blinks, respawns after RESPAWN_FRAMES frames
module ship_controller #(
  parameter int START_X        = 320,
  parameter int START_Y        = 240,
  parameter int X_MIN          = 30,
  parameter int X_MAX          = 608,
  parameter int SPEED          = 3,
  parameter int AMMO           = 4,
  parameter int RELOAD_FRAMES  = 30,
  parameter int RESPAWN_FRAMES = 90
) (
  input  logic                      clk_60hz,
  input  logic                      reset,
  input  logic                      left,
  input  logic                      right,
  input  logic                      fire,
  input  logic                      hit,
  input  logic [9:0]                px,
  input  logic [9:0]                py,
  ship_controller_if.master         bus,
  output logic                      pixel,
  output logic [9:0]                ship_x_center,
  output logic [2:0]                ammo_count,
  output logic                      alive
);

  // Timer must cover the longer of the two waits; at least 4 bits for the blink tap.
  localparam int T_MAX = (RELOAD_FRAMES > RESPAWN_FRAMES) ? RELOAD_FRAMES : RESPAWN_FRAMES;
  localparam int TW    = ($clog2(T_MAX) < 4) ? 4 : $clog2(T_MAX);

  typedef enum logic [1:0] {
    READY  = 2'd0,
    SHOT   = 2'd1,
    RELOAD = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t        state_q, state_nxt;
  logic [9:0]    ship_x_q, ship_x_nxt;
  logic [2:0]    ammo_q, ammo_nxt;
  logic          shot_valid_q, shot_valid_nxt;
  logic [9:0]    shot_x_q, shot_x_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          fire_q;
  logic          fire_edge;

  assign fire_edge = fire && !fire_q;

  // Frame registers, asynchronously cleared to the power-on position and full magazine.
  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      state_q      <= READY;
      ship_x_q     <= 10'(START_X);
      ammo_q       <= 3'(AMMO);
      shot_valid_q <= 1'b0;
      shot_x_q     <= 10'd0;
      timer_q      <= '0;
      fire_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ship_x_q     <= ship_x_nxt;
      ammo_q       <= ammo_nxt;
      shot_valid_q <= shot_valid_nxt;
      shot_x_q     <= shot_x_nxt;
      timer_q      <= timer_nxt;
      fire_q       <= fire;
    end
  end

  // Next-state and datapath: hit beats ack/reload/respawn, which beat fire.
  always_comb begin
    state_nxt      = state_q;
    ship_x_nxt     = ship_x_q;
    ammo_nxt       = ammo_q;
    shot_valid_nxt = shot_valid_q;
    shot_x_nxt     = shot_x_q;
    timer_nxt      = timer_q;

    // Saturating movement; compare in 11 bits before subtracting so nothing wraps.
    if (state_q != DEAD) begin
      if (left) begin
        if ({1'b0, ship_x_q} >= 11'(X_MIN + SPEED))
          ship_x_nxt = ship_x_q - 10'(SPEED);
        else
          ship_x_nxt = 10'(X_MIN);
      end else if (right) begin
        if ({1'b0, ship_x_q} + 11'(SPEED) > 11'(X_MAX))
          ship_x_nxt = 10'(X_MAX);
        else
          ship_x_nxt = ship_x_q + 10'(SPEED);
      end
    end

    if (state_q != DEAD && hit) begin
      // A pending shot is simply dropped; the magazine is not charged for it.
      state_nxt      = DEAD;
      shot_valid_nxt = 1'b0;
      timer_nxt      = '0;
    end else begin
      case (state_q)
        READY: begin
          if (fire_edge && ammo_q != 3'd0) begin
            state_nxt      = SHOT;
            shot_valid_nxt = 1'b1;
            shot_x_nxt     = ship_x_q + 10'd16;
          end
        end
        SHOT: begin
          if (bus.shot_ack) begin
            shot_valid_nxt = 1'b0;
            ammo_nxt       = ammo_q - 3'd1;
            if (ammo_q == 3'd1) begin
              state_nxt = RELOAD;
              timer_nxt = '0;
            end else begin
              state_nxt = READY;
            end
          end
        end
        RELOAD: begin
          if (timer_q == TW'(RELOAD_FRAMES - 1)) begin
            ammo_nxt  = 3'(AMMO);
            state_nxt = READY;
          end else begin
            timer_nxt = timer_q + 1'b1;
          end
        end
        DEAD: begin
          if (timer_q == TW'(RESPAWN_FRAMES - 1)) begin
            ship_x_nxt = 10'(START_X);
            ammo_nxt   = 3'(AMMO);
            state_nxt  = READY;
          end else begin
            timer_nxt = timer_q + 1'b1;
          end
        end
        default: state_nxt = READY;
      endcase
    end
  end

  assign bus.shot_valid = shot_valid_q;
  assign bus.shot_x     = shot_x_q;
  assign ammo_count     = ammo_q;
  assign alive          = (state_q != DEAD);
  assign ship_x_center  = ship_x_q + 10'd16;

  logic       in_x, in_y;
  logic [9:0] col, row;
  logic [9:0] lo, hi;
  logic       body_on, slot_dark, visible;

  // Sprite lookup: 12-row hull with ammo slots punched dark while rounds remain.
  always_comb begin
    in_x      = (px >= ship_x_q);
    in_y      = (py >= 10'(START_Y));
    col       = px - ship_x_q;
    row       = py - 10'(START_Y);
    lo        = 10'd0;
    hi        = 10'd0;
    slot_dark = 1'b0;

    case (row)
      10'd0, 10'd11:                    begin lo = 10'd10; hi = 10'd22; end
      10'd1, 10'd10:                    begin lo = 10'd6;  hi = 10'd26; end
      10'd2, 10'd9:                     begin lo = 10'd4;  hi = 10'd28; end
      10'd3, 10'd4, 10'd5, 10'd6,
      10'd7, 10'd8:                     begin lo = 10'd2;  hi = 10'd30; end
      default:                          begin lo = 10'd1;  hi = 10'd0;  end
    endcase

    body_on = in_x && in_y && (row < 10'd12) && (col >= lo) && (col <= hi);

    if (row >= 10'd4 && row <= 10'd8) begin
      for (int i = 0; i < AMMO; i++) begin
        if ((col == 10'(11 + 3 * i) || col == 10'(12 + 3 * i)) && (3'(i) < ammo_q))
          slot_dark = 1'b1;
      end
    end

    visible = (state_q != DEAD) || timer_q[3];
    pixel   = visible && body_on && !slot_dark;
  end

endmodule

// File: tb/tb_ship_controller.sv
// Directed bench for ship_controller with hand-computed expectations.
module tb_ship_controller;
  logic       clk_60hz = 1'b0;
  logic       reset;
  logic       left, right, fire, hit;
  logic [9:0] px, py;
  logic       pixel;
  logic [9:0] ship_x_center;
  logic [2:0] ammo_count;
  logic       alive;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_x;

  ship_controller_if sif ();

  ship_controller dut (
    .clk_60hz      (clk_60hz),
    .reset         (reset),
    .left          (left),
    .right         (right),
    .fire          (fire),
    .hit           (hit),
    .px            (px),
    .py            (py),
    .bus           (sif.master),
    .pixel         (pixel),
    .ship_x_center (ship_x_center),
    .ammo_count    (ammo_count),
    .alive         (alive)
  );

  always #5 clk_60hz = ~clk_60hz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_60hz);
    #1;
  endtask

  task automatic fire_shot(input logic [2:0] exp_ammo_after);
    fire = 1'b1;
    step();
    chk("shot_valid_up", sif.shot_valid, 1);
    fire = 1'b0;
    step();
    chk("shot_valid_down", sif.shot_valid, 0);
    chk("ammo_after_shot", ammo_count, exp_ammo_after);
  endtask

  initial begin
    reset = 1'b1; left = 0; right = 0; fire = 0; hit = 0;
    sif.shot_ack = 1'b0;
    px = 10'd330; py = 10'd240;
    #12;
    chk("rst_center", ship_x_center, 336);
    chk("rst_ammo", ammo_count, 4);
    chk("rst_valid", sif.shot_valid, 0);
    chk("rst_shot_x", sif.shot_x, 0);
    chk("rst_alive", alive, 1);
    chk("rst_pix_r0c10", pixel, 1);
    px = 10'd320; #1;
    chk("rst_pix_r0c0", pixel, 0);
    px = 10'd331; py = 10'd244; #1;
    chk("rst_pix_slot0", pixel, 0);
    px = 10'd319; #1;
    chk("rst_pix_left_of_ship", pixel, 0);
    px = 10'd330; py = 10'd239; #1;
    chk("rst_pix_above_ship", pixel, 0);
    @(negedge clk_60hz);
    reset = 1'b0;

    // Hold left, then right: saturate at both bounds.
    exp_x = 320;
    left = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_x = (exp_x >= 33) ? exp_x - 3 : 30;
      chk("left_x", ship_x_center, exp_x + 16);
    end
    left = 1'b0; right = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      exp_x = (exp_x + 3 > 608) ? 608 : exp_x + 3;
      chk("right_x", ship_x_center, exp_x + 16);
    end
    right = 1'b0;
    chk("right_sat", ship_x_center, 624);

    // Held fire with ack tied high: one shot only.
    sif.shot_ack = 1'b1;
    fire = 1'b1;
    step();
    chk("held_valid", sif.shot_valid, 1);
    chk("held_shot_x", sif.shot_x, 624);
    step();
    chk("held_ammo3", ammo_count, 3);
    chk("held_valid_down", sif.shot_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_no_repeat_v", sif.shot_valid, 0);
      chk("held_no_repeat_a", ammo_count, 3);
    end
    fire = 1'b0;
    step();
    fire_shot(3'd2);
    fire_shot(3'd1);
    fire_shot(3'd0);

    // Empty magazine: RELOAD ignores fire for 30 frames.
    for (int i = 1; i < 30; i++) begin
      fire = i[0];
      step();
      chk("reload_ammo0", ammo_count, 0);
      chk("reload_no_shot", sif.shot_valid, 0);
    end
    fire = 1'b0;
    step();
    chk("reload_done", ammo_count, 4);

    // Ack withheld for 5 frames.
    sif.shot_ack = 1'b0;
    fire = 1'b1;
    step();
    fire = 1'b0;
    chk("wait_valid", sif.shot_valid, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wait_valid_hold", sif.shot_valid, 1);
      chk("wait_shot_x", sif.shot_x, 624);
      chk("wait_ammo", ammo_count, 4);
    end
    sif.shot_ack = 1'b1;
    step();
    sif.shot_ack = 1'b0;
    chk("late_ack_valid", sif.shot_valid, 0);
    chk("late_ack_ammo", ammo_count, 3);
    px = 10'd628; py = 10'd245; #1;
    chk("pix_slot3_lit", pixel, 1);
    px = 10'd619; py = 10'd244; #1;
    chk("pix_slot0_dark", pixel, 0);

    // Hit with a shot pending.
    fire = 1'b1;
    step();
    fire = 1'b0;
    chk("pre_hit_valid", sif.shot_valid, 1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("hit_alive", alive, 0);
    chk("hit_valid", sif.shot_valid, 0);
    chk("hit_ammo", ammo_count, 3);
    px = 10'd618; py = 10'd240;
    left = 1'b1;
    for (int k = 0; k < 90; k++) begin
      #1;
      chk("blink", pixel, (k >> 3) & 1);
      chk("dead_alive", alive, 0);
      if (k == 20) chk("dead_no_move", ship_x_center, 624);
      if (k == 89) left = 1'b0;
      hit = (k == 50);
      step();
    end
    hit = 1'b0;
    chk("respawn_alive", alive, 1);
    chk("respawn_x", ship_x_center, 336);
    chk("respawn_ammo", ammo_count, 4);

    // Reset in the middle of RELOAD.
    sif.shot_ack = 1'b1;
    fire_shot(3'd3);
    fire_shot(3'd2);
    fire_shot(3'd1);
    fire_shot(3'd0);
    step(); step(); step();
    chk("mid_reload_ammo", ammo_count, 0);
    chk("mid_reload_shot_x", sif.shot_x, 336);
    reset = 1'b1;
    px = 10'd330; py = 10'd240;
    #1;
    chk("areset_ammo", ammo_count, 4);
    chk("areset_valid", sif.shot_valid, 0);
    chk("areset_shot_x", sif.shot_x, 0);
    chk("areset_alive", alive, 1);
    chk("areset_center", ship_x_center, 336);
    chk("areset_pix_on", pixel, 1);
    px = 10'd331; py = 10'd244; #1;
    chk("areset_pix_slot", pixel, 0);
    @(negedge clk_60hz);
    reset = 1'b0;
    step();
    chk("post_reset_ammo", ammo_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
